uart_rx_frame_fifo: RTL and testbench

Receive-side stage directly downstream of the UART start-bit detector/frame capture block. It takes each captured 12-bit raw frame and its write strobe, decodes the frame against the current character format (5–8 data bits, optional parity, 1 or 2 stop bits), and flags parity and framing errors. It stores data plus error flags in a first-word-fall-through FIFO that the CPU-side register interface drains, and reports occupancy and a sticky overrun.

---
 rtl/uart_rx_frame_fifo.sv | 91 +++++++++
 tb/tb_uart_rx_frame_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_fifo.sv
// uart_rx_frame_fifo: decodes captured UART frames into a FWFT FIFO with parity/framing flags and sticky overrun
module uart_rx_frame_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          frame_valid_i,
  input  logic [11:0]   frame_i,
  input  logic [3:0]    number_data_receive,
  input  logic          parity_bit_mode,
  input  logic          parity_odd_i,
  input  logic          stop_bit_twice,
  input  logic          flush_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          rd_pe_o,
  output logic          rd_fe_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o,
  output logic          overrun_o,
  input  logic          clear_overrun_i
);
  logic [3:0]    n, s;
  logic [7:0]    mask, dec_data;
  logic          par, dec_pe, dec_fe;
  logic          pend;
  logic [9:0]    ent;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, cnt_nx;
  logic          empty, full, ovr, do_wr, do_rd, drop;

  always_comb begin
    n = (number_data_receive == 4'd6 || number_data_receive == 4'd7 || number_data_receive == 4'd8)
        ? number_data_receive : 4'd5;
    mask = n == 4'd8 ? 8'hff : n == 4'd7 ? 8'h7f : n == 4'd6 ? 8'h3f : 8'h1f;
    dec_data = frame_i[8:1] & mask;
    par = frame_i[n + 4'd1];
    s = n + 4'd1 + {3'b0, parity_bit_mode};
    dec_pe = parity_bit_mode & ((^dec_data ^ par) != parity_odd_i);
    dec_fe = frame_i[0] | ~frame_i[s] | (stop_bit_twice & ~frame_i[s + 4'd1]);
  end

  // a full FIFO still accepts a write when the same cycle frees a slot
  assign do_rd  = rd_en_i & ~empty & ~flush_i;
  assign do_wr  = pend & ~flush_i & (~full | do_rd);
  assign drop   = pend & full & ~do_rd;
  assign cnt_nx = cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend   <= 1'b0;
      ent    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovr    <= 1'b0;
    end else if (flush_i) begin
      pend   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      pend   <= frame_valid_i;
      if (frame_valid_i) ent <= {dec_fe, dec_pe, dec_data};
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      cnt    <= cnt_nx;
      empty  <= cnt_nx == '0;
      full   <= cnt_nx == (AW+1)'(DEPTH);
      ovr    <= drop | (ovr & ~clear_overrun_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= ent;
  end

  assign {rd_fe_o, rd_pe_o, rd_data_o} = empty ? 10'd0 : mem[rd_ptr];
  assign empty_o   = empty;
  assign full_o    = full;
  assign count_o   = cnt;
  assign overrun_o = ovr;
endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// tb_uart_rx_frame_fifo: directed vector table for decode plus hand sequences for fill, wrap, overrun, flush and reset
module tb_uart_rx_frame_fifo;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        frame_valid_i = 1'b0;
  logic [11:0] frame_i = '0;
  logic [3:0]  number_data_receive = 4'd8;
  logic        parity_bit_mode = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        stop_bit_twice = 1'b0;
  logic        flush_i = 1'b0;
  logic        rd_en_i = 1'b0;
  logic        clear_overrun_i = 1'b0;
  logic [7:0]  rd_data_o;
  logic        rd_pe_o, rd_fe_o, empty_o, full_o, overrun_o;
  logic [4:0]  count_o;
  int          n_tests = 0;
  int          n_fail = 0;

  uart_rx_frame_fifo #(.DEPTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .frame_valid_i(frame_valid_i), .frame_i(frame_i),
    .number_data_receive(number_data_receive), .parity_bit_mode(parity_bit_mode),
    .parity_odd_i(parity_odd_i), .stop_bit_twice(stop_bit_twice), .flush_i(flush_i),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_pe_o(rd_pe_o), .rd_fe_o(rd_fe_o),
    .empty_o(empty_o), .full_o(full_o), .count_o(count_o), .overrun_o(overrun_o),
    .clear_overrun_i(clear_overrun_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [11:0] frame;
    logic [3:0]  nd;
    logic        pm, odd, sb2;
    logic [7:0]  data;
    logic        pe, fe;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] f8n1(input logic [7:0] d);
    return {2'b00, 1'b1, d, 1'b0};
  endfunction

  task automatic send(input logic [11:0] f);
    frame_valid_i = 1'b1;
    frame_i = f;
    step();
    frame_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"8N1",        {2'b00, 1'b1, 8'hA5, 1'b0},             4'd8, 0, 0, 0, 8'hA5, 0, 0};
    vecs[1] = '{"7E1_pe",     {2'b00, 1'b1, 1'b1, 7'h41, 1'b0},       4'd7, 1, 0, 0, 8'h41, 1, 0};
    vecs[2] = '{"7O1_ok",     {2'b00, 1'b1, 1'b1, 7'h41, 1'b0},       4'd7, 1, 1, 0, 8'h41, 0, 0};
    vecs[3] = '{"5N2_stop2",  {4'b0, 1'b0, 1'b1, 5'h15, 1'b0},        4'd0, 0, 0, 1, 8'h15, 0, 1};
    vecs[4] = '{"5N2_start",  {4'b0, 1'b1, 1'b1, 5'h0A, 1'b1},        4'd0, 0, 0, 1, 8'h0A, 0, 1};
    vecs[5] = '{"6O1_ok",     {3'b0, 1'b1, 1'b0, 6'h2C, 1'b0},        4'd6, 1, 1, 0, 8'h2C, 0, 0};
    vecs[6] = '{"8E2_ok",     {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0},        4'd8, 1, 0, 1, 8'h3C, 0, 0};
    vecs[7] = '{"nd9_is5",    {3'b0, 8'hFF, 1'b0},                    4'd9, 0, 0, 0, 8'h1F, 0, 0};
    vecs[8] = '{"8O2_stop2",  {1'b0, 1'b1, 1'b0, 8'h01, 1'b0},        4'd8, 1, 1, 1, 8'h01, 0, 1};

    step();
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_data", rd_data_o, 0);
    chk("rst_pe_fe", {rd_pe_o, rd_fe_o}, 0);
    rst_ni = 1'b1;
    step();

    foreach (vecs[i]) begin
      number_data_receive = vecs[i].nd;
      parity_bit_mode = vecs[i].pm;
      parity_odd_i = vecs[i].odd;
      stop_bit_twice = vecs[i].sb2;
      send(vecs[i].frame);
      chk({vecs[i].name, "_lat_empty"}, empty_o, 1);
      step();
      chk({vecs[i].name, "_count"}, count_o, 1);
      chk({vecs[i].name, "_data"}, rd_data_o, vecs[i].data);
      chk({vecs[i].name, "_pe"}, rd_pe_o, vecs[i].pe);
      chk({vecs[i].name, "_fe"}, rd_fe_o, vecs[i].fe);
      rd_en_i = 1'b1;
      step();
      rd_en_i = 1'b0;
      chk({vecs[i].name, "_pop_empty"}, empty_o, 1);
    end

    number_data_receive = 4'd8;
    parity_bit_mode = 1'b0;
    stop_bit_twice = 1'b0;
    frame_valid_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      frame_i = f8n1(i == 16 ? 8'hEE : 8'(i));
      step();
    end
    frame_valid_i = 1'b0;
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 16);
    chk("fill_ovr_late", overrun_o, 0);
    step();
    chk("drop_ovr", overrun_o, 1);
    chk("drop_count", count_o, 16);
    clear_overrun_i = 1'b1;
    step();
    clear_overrun_i = 1'b0;
    chk("clr_ovr", overrun_o, 0);

    for (int i = 0; i < 16; i++) begin
      chk("drain_data", rd_data_o, i);
      rd_en_i = 1'b1;
      step();
    end
    chk("drain_empty", empty_o, 1);
    chk("drain_count", count_o, 0);
    chk("drain_data0", rd_data_o, 0);
    step();
    rd_en_i = 1'b0;
    chk("rd_empty_ign", count_o, 0);
    send(f8n1(8'h5A));
    step();
    chk("wrap_count", count_o, 1);
    chk("wrap_data", rd_data_o, 8'h5A);
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;

    frame_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      frame_i = f8n1(8'h20 + 8'(i));
      step();
    end
    frame_valid_i = 1'b0;
    step();
    chk("full2", full_o, 1);
    send(f8n1(8'h77));
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    chk("rw_full_count", count_o, 16);
    chk("rw_full_ovr", overrun_o, 0);
    chk("rw_full_head", rd_data_o, 8'h21);
    send(f8n1(8'h88));
    clear_overrun_i = 1'b1;
    step();
    clear_overrun_i = 1'b0;
    chk("set_beats_clr", overrun_o, 1);

    send(f8n1(8'h99));
    frame_valid_i = 1'b1;
    frame_i = f8n1(8'h9A);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    frame_valid_i = 1'b0;
    chk("flush_count", count_o, 0);
    chk("flush_empty", empty_o, 1);
    chk("flush_ovr", overrun_o, 0);
    step();
    step();
    chk("flush_no_wr", count_o, 0);
    chk("flush_data", rd_data_o, 0);

    frame_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame_i = f8n1(8'h40 + 8'(i));
      step();
    end
    frame_valid_i = 1'b0;
    step();
    chk("pre_rst_count", count_o, 5);
    chk("pre_rst_head", rd_data_o, 8'h40);
    rst_ni = 1'b0;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_empty", empty_o, 1);
    chk("arst_data", rd_data_o, 0);
    chk("arst_full_ovr", {full_o, overrun_o}, 0);
    step();
    rst_ni = 1'b1;
    step();
    chk("post_rst_count", count_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
